color_sensor_emulator: RTL and testbench
========================================

# color_sensor_emulator

Synthesizable model of the light-to-frequency colour sensor that the rover's colour-sensing logic drives. It receives the `filter` and `scale` select lines from the sensor controller and produces the `sensorFreq` square wave. The output frequency depends on a programmable per-channel intensity and on the selected output scaling. It is used in simulation benches and on FPGA loopback builds in place of the physical sensor, so the controller and frequency counter can be exercised with known colours.

## Interface

Parameters:
- `DEF_RED`, 16'd500: reset half-period (clk cycles at 100 % scale), red channel.
- `DEF_BLUE`, 16'd800: reset half-period, blue channel.
- `DEF_GREEN`, 16'd900: reset half-period, green channel.
- `DEF_CLEAR`, 16'd200: reset half-period, clear channel.
- `SETTLE`, 8'd16: cycles that `sensor_out` is held low after a filter or scale change.

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `filter`, input, 2: channel select. 00 = red, 01 = blue, 11 = green, 10 = clear.
- `scale`, input, 2: output scaling. 00 = power-down, 01 = 2 % (×50), 10 = 20 % (×5), 11 = 100 % (×1).
- `cfg_we`, input, 1: one-cycle write strobe for a half-period register.
- `cfg_sel`, input, 2: register to write, using the same encoding as `filter`.
- `cfg_data`, input, 16: new base half-period.
- `sensor_out`, output, 1: emulated frequency output. Connects to the controller's `sensorFreq`.
- `busy`, output, 1: high while in SETTLE.

## Operation

**Registers**
- Four 16-bit base half-period registers, one per channel. They reset to `DEF_*`.
- A `cfg_we` write lands on the next rising clock edge.

**Effective half-period**
- H = base[filter] × mult(scale), where mult is 50, 5 or 1.
- H is 22 bits wide; the maximum is 65535 × 50 < 2^22, so no overflow.
- The half-period counter is 22 bits wide and counts down from H−1 to 0.

**State machine** (states OFF, SETTLE, RUN)
- Reset enters OFF.
- OFF:
  - `sensor_out` = 0.
  - Goes to SETTLE when `scale` ≠ 00 (the first sampled cycle).
- SETTLE:
  - `sensor_out` = 0 and `busy` = 1.
  - The settle counter counts `SETTLE` cycles.
  - Then go to RUN and load the counter with H−1.
- RUN:
  - When the counter reaches 0, toggle `sensor_out` and reload H−1.
  - The first toggle is 0→1.
- Any state: if `scale` = 00, go to OFF on the next edge.
- SETTLE or RUN: a change of `filter` or `scale` (compared against a 1-cycle registered copy, with the new scale ≠ 00) goes to SETTLE and restarts the settle count.

**Boundary conditions**
- Base = 0 for the selected channel: RUN holds `sensor_out` low and does not toggle. Toggling resumes at the next reload after a non-zero value is written.
- Write to the active channel during RUN: the new value takes effect at the next reload only. The current half-period completes unchanged and no glitch is allowed.
- Write in the same cycle as a filter change: SETTLE is entered, and the value loaded on RUN entry is the newly written one.
- `rst_n` low at any time: immediately OFF, `sensor_out` = 0, `busy` = 0, registers reset to `DEF_*`.

## Timing

**Reset values**
- `sensor_out` = 0, `busy` = 0, state OFF.
- Counters = 0, previous-select copies = 00.

**Latencies**
- Select change to `busy` rising: 2 cycles (1 cycle to register, 1 cycle to detect).
- SETTLE to first rising edge of `sensor_out`: SETTLE + H cycles.
- Steady state:
  - Output period = 2H cycles with a 50 % duty cycle.
  - Frequency = f_clk / (2H).

**Other rules**
- No combinational path from inputs to `sensor_out`; the output is registered.
- `cfg_*` has no handshake. The write is accepted every cycle that `cfg_we` = 1.

## Structure

**Shared package** (`color_sensor_pkg`):
- Filter encodings: `FLT_RED`, `FLT_BLUE`, `FLT_GREEN`, `FLT_CLEAR`.
- Scale encodings and multipliers: `SCL_OFF`, `SCL_2`, `SCL_20`, `SCL_100`; 50, 5, 1.
- State enum: OFF, SETTLE, RUN.

The controller and the frequency counter import the same package.

**Sub-module**
- One natural sub-module, `half_period_gen`: a loadable down-counter with a toggle flop.
- Inputs: load value, enable, restart.
- Output: the square wave.
- The top level keeps the register file, the multiplier mux and the FSM.

## Test plan

- **Reset defaults:** reset, then `filter`=00, `scale`=11 → first rise at 16+500 cycles after reaching SETTLE; period 1000 cycles; `busy` high for exactly 16 cycles.
- **Scale change:** `filter`=01, `scale`=10 → period 8000 cycles. Switch `scale` to 01 → `busy` rises 2 cycles later, output stays low for 16 cycles, then period 80000 cycles.
- **Power-down:** `scale`=00 mid-RUN → `sensor_out` goes 0 on the next edge and stays 0. Restore 11 → resumes via SETTLE.
- **Mid-half-period write:** write red=100 with `cfg_sel`=00 mid-half-period while red is active → current half-period stays 500 cycles, subsequent half-periods are 100 cycles, no extra edges.
- **Zero base:** write green=0, select `filter`=11 → `sensor_out` stays low for 10000 cycles. Write green=50 → toggling at 100-cycle period begins.
- **Async reset mid-RUN:** assert `rst_n` low for 3 cycles during RUN → `sensor_out` and `busy` drop immediately without waiting for a clock edge; a prior write of red=100 is lost and red reverts to 500.

Source files
------------

// File: rtl/color_sensor_emulator_pkg.sv
// ---------------------------------------------------------------------
// color_sensor_pkg: encodings and helpers shared by the sensor model,
// the colour-sensing controller and the frequency counter.  Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none
package color_sensor_pkg;

  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  localparam logic [1:0] SCL_OFF = 2'b00;
  localparam logic [1:0] SCL_2   = 2'b01;
  localparam logic [1:0] SCL_20  = 2'b10;
  localparam logic [1:0] SCL_100 = 2'b11;

  localparam logic [5:0] MULT_2   = 6'd50;
  localparam logic [5:0] MULT_20  = 6'd5;
  localparam logic [5:0] MULT_100 = 6'd1;

  localparam int HP_W = 22;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // 65535 * 50 fits in 22 bits, so the product never wraps.
  function automatic logic [HP_W-1:0] half_period(input logic [15:0] base,
                                                  input logic [1:0]  scl);
    logic [5:0] m;
    case (scl)
      SCL_2:   m = MULT_2;
      SCL_20:  m = MULT_20;
      SCL_100: m = MULT_100;
      default: m = 6'd0;
    endcase
    return {6'd0, base} * {16'd0, m};
  endfunction

endpackage
`default_nettype wire

// File: rtl/color_sensor_emulator_if.sv
// ---------------------------------------------------------------------
// color_sensor_emulator_if: select, config and output lines of the
// emulated colour sensor.  Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none
interface color_sensor_emulator_if;
  logic [1:0]  filter;
  logic [1:0]  scale;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        sensor_out;
  logic        busy;

  modport master (
    output filter, scale, cfg_we, cfg_sel, cfg_data,
    input  sensor_out, busy
  );

  modport slave (
    input  filter, scale, cfg_we, cfg_sel, cfg_data,
    output sensor_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/color_sensor_emulator_half_period_gen.sv
// ---------------------------------------------------------------------
// half_period_gen: loadable down-counter toggling a square wave every
// load_val cycles.  Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none
module half_period_gen
  import color_sensor_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HP_W-1:0] load_val,
  input  logic            enable,
  input  logic            restart,
  output logic            wave
);

  logic [HP_W-1:0] r_cnt;

  // load_val is only sampled at a reload, so a new value never cuts the
  // half-period in progress; a zero value parks the wave low until the
  // next reload sees a non-zero one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      wave  <= 1'b0;
    end else if (!enable) begin
      r_cnt <= '0;
      wave  <= 1'b0;
    end else if (restart) begin
      r_cnt <= (load_val == '0) ? '0 : load_val - 1'b1;
      wave  <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (load_val == '0) begin
      wave  <= 1'b0;
    end else begin
      r_cnt <= load_val - 1'b1;
      wave  <= ~wave;
    end
  end

endmodule
`default_nettype wire

// File: rtl/color_sensor_emulator.sv
// ---------------------------------------------------------------------
// color_sensor_emulator: light-to-frequency colour sensor model with
// programmable per-channel half-periods.  Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none
module color_sensor_emulator
  import color_sensor_pkg::*;
#(
  parameter logic [15:0] DEF_RED   = 16'd500,
  parameter logic [15:0] DEF_BLUE  = 16'd800,
  parameter logic [15:0] DEF_GREEN = 16'd900,
  parameter logic [15:0] DEF_CLEAR = 16'd200,
  parameter logic [7:0]  SETTLE    = 8'd16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  color_sensor_emulator_if.slave  bus
);

  logic [15:0]     r_base [4];
  logic [1:0]      r_flt_q, r_scl_q, r_flt_prev, r_scl_prev;
  logic [7:0]      r_settle_cnt;
  logic            r_busy;
  state_t          r_state, w_nxt;
  logic            w_sel_change, w_settle_start;
  logic            w_gen_en, w_gen_restart, w_wave;
  logic [HP_W-1:0] w_hp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base[FLT_RED]   <= DEF_RED;
      r_base[FLT_BLUE]  <= DEF_BLUE;
      r_base[FLT_CLEAR] <= DEF_CLEAR;
      r_base[FLT_GREEN] <= DEF_GREEN;
    end else if (bus.cfg_we) begin
      r_base[bus.cfg_sel] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt_q    <= 2'b00;
      r_scl_q    <= 2'b00;
      r_flt_prev <= 2'b00;
      r_scl_prev <= 2'b00;
    end else begin
      r_flt_q    <= bus.filter;
      r_scl_q    <= bus.scale;
      r_flt_prev <= r_flt_q;
      r_scl_prev <= r_scl_q;
    end
  end

  assign w_hp         = half_period(r_base[r_flt_q], r_scl_q);
  assign w_sel_change = (r_flt_q != r_flt_prev) || (r_scl_q != r_scl_prev);

  // Power-down acts on the raw scale so the output drops on the next edge.
  always_comb begin
    w_nxt          = r_state;
    w_settle_start = 1'b0;
    if (bus.scale == SCL_OFF) begin
      w_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (r_scl_q != SCL_OFF) begin
            w_nxt          = ST_SETTLE;
            w_settle_start = 1'b1;
          end
        end
        ST_SETTLE, ST_RUN: begin
          if (w_sel_change && (r_scl_q != SCL_OFF)) begin
            w_nxt          = ST_SETTLE;
            w_settle_start = 1'b1;
          end else if ((r_state == ST_SETTLE) && (r_settle_cnt == SETTLE - 8'd1)) begin
            w_nxt = ST_RUN;
          end
        end
        default: w_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_busy       <= 1'b0;
      r_settle_cnt <= 8'd0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt == ST_SETTLE);
      if (w_settle_start || (r_state != ST_SETTLE)) begin
        r_settle_cnt <= 8'd0;
      end else begin
        r_settle_cnt <= r_settle_cnt + 8'd1;
      end
    end
  end

  assign w_gen_en      = (w_nxt == ST_RUN);
  assign w_gen_restart = (w_nxt == ST_RUN) && (r_state != ST_RUN);

  half_period_gen u_half_period_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val (w_hp),
    .enable   (w_gen_en),
    .restart  (w_gen_restart),
    .wave     (w_wave)
  );

  assign bus.sensor_out = w_wave;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_color_sensor_emulator.sv
// ---------------------------------------------------------------------
// tb_color_sensor_emulator: directed/randomized bench timing sensor_out
// edges against a half-period model.  Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none
module tb_color_sensor_emulator;

  localparam int SETTLE_C = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   model_base [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  color_sensor_emulator_if bus ();

  color_sensor_emulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model indexed by filter code: 0 red, 1 blue, 2 clear, 3 green.
  task automatic model_reset();
    model_base[0] = 500;
    model_base[1] = 800;
    model_base[2] = 200;
    model_base[3] = 900;
  endtask

  function automatic int exp_half(input int f, input int s);
    int m;
    case (s)
      1:       m = 50;
      2:       m = 5;
      3:       m = 1;
      default: m = 0;
    endcase
    return model_base[f] * m;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input bit use_busy, input logic val, input int limit,
                          output int at, output int out_high);
    at       = -1;
    out_high = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (bus.sensor_out === 1'b1) out_high++;
      if ((use_busy ? bus.busy : bus.sensor_out) === val) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_data = 16'(data);
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
    model_base[sel] = data;
  endtask

  // From a select change at cycle t0: settle window, first rise, one period.
  task automatic run_check(input string tag, input int t0, input int h, output int last);
    int tb_s, te, tr, tf, hi;
    wait_for(1'b1, 1'b1, 20, tb_s, hi);
    check({tag, "_busy_lat"}, tb_s - t0, 2);
    check({tag, "_settle_low"}, bus.sensor_out, 0);
    wait_for(1'b1, 1'b0, 100, te, hi);
    check({tag, "_busy_len"}, te - tb_s, SETTLE_C);
    check({tag, "_settle_out_high"}, hi, 0);
    wait_for(1'b0, 1'b1, h + 100, tr, hi);
    check({tag, "_first_rise"}, tr - tb_s, SETTLE_C + h);
    wait_for(1'b0, 1'b0, h + 100, tf, hi);
    check({tag, "_high"}, tf - tr, h);
    wait_for(1'b0, 1'b1, h + 100, last, hi);
    check({tag, "_low"}, last - tf, h);
  endtask

  initial begin
    int t0, at, at2, hi, v, f, k, last, h_old, h_new, tr, tf;
    bus.filter   = 2'b00;
    bus.scale    = 2'b00;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 2'b00;
    bus.cfg_data = 16'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", bus.sensor_out, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    bus.filter = 2'b00; bus.scale = 2'b11; t0 = cyc;
    run_check("dflt", t0, exp_half(0, 3), last);

    bus.filter = 2'b01; bus.scale = 2'b10; t0 = cyc;
    run_check("blue20", t0, exp_half(1, 2), last);

    v = $urandom_range(8, 40);
    cfg_write(2'b01, v);
    bus.scale = 2'b01; t0 = cyc;
    run_check("blue2", t0, exp_half(1, 1), last);

    bus.scale = 2'b00;
    @(posedge clk); #1;
    check("pd_out", bus.sensor_out, 0);
    check("pd_busy", bus.busy, 0);
    wait_for(1'b0, 1'b1, 60, at, hi);
    check("pd_hold", hi, 0);

    f = $urandom_range(1, 3);
    bus.filter = 2'(f); bus.scale = 2'b11; t0 = cyc;
    run_check("restore", t0, exp_half(f, 3), last);

    bus.filter = 2'b00; t0 = cyc;
    run_check("red", t0, exp_half(0, 3), last);
    k = $urandom_range(50, 400);
    repeat (k) @(posedge clk);
    #1;
    h_old = exp_half(0, 3);
    cfg_write(2'b00, 100);
    h_new = exp_half(0, 3);
    wait_for(1'b0, 1'b0, h_old + 100, tf, hi);
    check("mw_cur_half", tf - last, h_old);
    wait_for(1'b0, 1'b1, h_new + 100, tr, hi);
    check("mw_low", tr - tf, h_new);
    wait_for(1'b0, 1'b0, h_new + 100, tf, hi);
    check("mw_high", tf - tr, h_new);
    check("mw_busy", bus.busy, 0);

    bus.filter   = 2'b11;
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 2'b11;
    bus.cfg_data = 16'd0;
    t0 = cyc;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    model_base[3] = 0;
    wait_for(1'b1, 1'b1, 20, at, hi);
    check("zero_busy_lat", at - t0, 2);
    wait_for(1'b1, 1'b0, 100, at2, hi);
    check("zero_busy_len", at2 - at, SETTLE_C);
    wait_for(1'b0, 1'b1, 10000, at, hi);
    check("zero_hold", hi, 0);
    v = $urandom_range(20, 80);
    cfg_write(2'b11, v);
    wait_for(1'b0, 1'b1, 200, tr, hi);
    check("zero_resume", (tr >= 0), 1);
    wait_for(1'b0, 1'b0, v + 100, tf, hi);
    check("zero_high", tf - tr, exp_half(3, 3));
    wait_for(1'b0, 1'b1, v + 100, tr, hi);
    check("zero_low", tr - tf, exp_half(3, 3));

    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", bus.sensor_out, 0);
    check("arst_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    bus.filter = 2'b00; bus.scale = 2'b11; t0 = cyc;
    run_check("post_rst", t0, exp_half(0, 3), last);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
